// File: rtl/lab62_soc_multi_pio.sv
// Multi-channel double-buffered Avalon-MM output PIO: software fills shadow
// registers, live outputs load immediately (IMM) or atomically on a commit.
module lab62_soc_multi_pio #(
  parameter int         DATA_WIDTH = 20,
  parameter int         NUM_CH     = 4,
  parameter int         ADDR_W     = 4,
  parameter logic [1:0] CTRL_RESET = 2'b01
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  input  logic                         frame_sync,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_port,
  output logic                         commit_pulse,
  output logic                         pending
);

  // Avalon slave handshake: zero wait states. A write is accepted on every
  // rising edge where chipselect & ~write_n; readdata is a combinational
  // function of address and register state, valid in the same cycle.

  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(2 * NUM_CH);
  localparam logic [ADDR_W-1:0] CMT_ADDR  = ADDR_W'(2 * NUM_CH + 1);

  typedef logic [NUM_CH-1:0][DATA_WIDTH-1:0] bank_t;

  bank_t       shadow_q, shadow_d;
  bank_t       live_q, live_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pending_q, pending_d;
  logic        pulse_q, pulse_d;
  logic        fs_q, fs_d;

  logic              wr;
  logic              fs_rise;
  logic              commit_evt;
  logic              shadow_wr;
  logic [NUM_CH-1:0] ch_sel;
  logic              unused_wd;

  // Upper writedata bits are don't-care for narrow channels.
  assign unused_wd = ^writedata;

  always_comb begin
    wr      = chipselect & ~write_n;
    fs_rise = frame_sync & ~fs_q;
    ch_sel  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = wr && (address == ADDR_W'(i));
    end
    shadow_wr  = |ch_sel;
    commit_evt = (wr && (address == CMT_ADDR)) || (ctrl_q[1] && fs_rise);
  end

  always_comb begin
    shadow_d  = shadow_q;
    live_d    = live_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    pulse_d   = commit_evt;
    fs_d      = frame_sync;

    // Commit copies the pre-edge shadow; a same-cycle shadow write is not part of it.
    if (commit_evt) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i]) begin
        shadow_d[i] = writedata[DATA_WIDTH-1:0];
        if (ctrl_q[0]) begin
          live_d[i] = writedata[DATA_WIDTH-1:0];
        end
      end
    end

    if (shadow_wr && !ctrl_q[0]) begin
      pending_d = 1'b1;
    end

    if (wr && (address == CTRL_ADDR)) begin
      ctrl_d = writedata[1:0];
    end
  end

  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (address == ADDR_W'(i)) begin
        readdata[DATA_WIDTH-1:0] = shadow_q[i];
      end
      if (address == ADDR_W'(NUM_CH + i)) begin
        readdata[DATA_WIDTH-1:0] = live_q[i];
      end
    end
    if (address == CTRL_ADDR) begin
      readdata[1:0] = ctrl_q;
    end
    if (address == CMT_ADDR) begin
      readdata[0] = pending_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q  <= '0;
      live_q    <= '0;
      ctrl_q    <= CTRL_RESET;
      pending_q <= 1'b0;
      pulse_q   <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      live_q    <= live_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      fs_q      <= fs_d;
    end
  end

  assign out_port     = live_q;
  assign commit_pulse = pulse_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_lab62_soc_multi_pio.sv
// Bench for lab62_soc_multi_pio: a transaction-level register model predicts
// reads and post-edge outputs; a negedge monitor pops and compares.
module tb_lab62_soc_multi_pio;

  localparam int DW   = 20;
  localparam int NCH  = 4;
  localparam int AW   = 4;
  localparam int OW   = NCH * DW;
  localparam logic [31:0] MASK = 32'h000F_FFFF;

  logic          clk;
  logic          reset;
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          frame_sync;
  logic [OW-1:0] out_port;
  logic          commit_pulse;
  logic          pending;

  lab62_soc_multi_pio #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .ADDR_W(AW), .CTRL_RESET(2'b01)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .frame_sync(frame_sync), .out_port(out_port),
    .commit_pulse(commit_pulse), .pending(pending)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  logic [31:0]   exp_q[$];
  logic [OW+1:0] st_q[$];

  // Reference model: plain register arrays updated per bus transaction
  logic [31:0] m_sh[NCH];
  logic [31:0] m_lv[NCH];
  logic [1:0]  m_ctrl;
  bit          m_pend;
  bit          m_pulse;
  bit          m_fs;
  bit          cur_fs;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh[i] = 0;
      m_lv[i] = 0;
    end
    m_ctrl  = 2'b01;
    m_pend  = 0;
    m_pulse = 0;
    m_fs    = 0;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a < NCH)          return m_sh[a];
    else if (a < 2 * NCH) return m_lv[a - NCH];
    else if (a == 2 * NCH)     return {30'b0, m_ctrl};
    else if (a == 2 * NCH + 1) return {31'b0, m_pend};
    else                  return 32'h0;
  endfunction

  function automatic void model_update(input int a, input bit cs, input bit wn,
                                       input logic [31:0] wd, input bit fs);
    bit w;
    bit commit;
    w      = cs && !wn;
    commit = (w && a == 2 * NCH + 1) || (m_ctrl[1] && fs && !m_fs);
    if (commit) begin
      for (int i = 0; i < NCH; i++) m_lv[i] = m_sh[i];
      m_pend = 0;
    end
    if (w && a < NCH) begin
      m_sh[a] = wd & MASK;
      if (m_ctrl[0]) m_lv[a] = wd & MASK;
      else           m_pend = 1;
    end
    if (w && a == 2 * NCH) m_ctrl = wd[1:0];
    m_fs    = fs;
    m_pulse = commit;
  endfunction

  function automatic logic [OW+1:0] model_state();
    logic [OW-1:0] op;
    for (int i = 0; i < NCH; i++) op[i*DW +: DW] = m_lv[i][DW-1:0];
    return {op, m_pulse, m_pend};
  endfunction

  // Driver tasks: one bus cycle each, inputs applied 1ns after posedge
  task automatic step(input int a, input bit cs, input bit wn, input logic [31:0] wd, input bit fs);
    address    = AW'(a);
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    frame_sync = fs;
    exp_q.push_back(model_read(a));
    model_update(a, cs, wn, wd, fs);
    @(posedge clk);
    #1;
    st_q.push_back(model_state());
  endtask

  task automatic wr_reg(input int a, input logic [31:0] d);
    step(a, 1'b1, 1'b0, d, cur_fs);
  endtask

  task automatic rd_reg(input int a);
    step(a, 1'b0, 1'b1, $urandom, cur_fs);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) rd_reg(2 * NCH + 1);
  endtask

  // Scoreboard monitor
  logic [OW+1:0] mon_s;
  logic [31:0]   mon_e;
  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      mon_s = st_q.pop_front();
      chk("out_port", out_port, mon_s[OW+1:2]);
      chk("commit_pulse", commit_pulse, mon_s[1]);
      chk("pending", pending, mon_s[0]);
    end
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("readdata", readdata, mon_e);
    end
  end

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    frame_sync = 1'b0;
    cur_fs     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_port", out_port, '0);
    chk("reset_commit_pulse", commit_pulse, 1'b0);
    chk("reset_pending", pending, 1'b0);
    reset = 1'b0;

    // Read back every address after reset
    for (int a = 0; a < 16; a++) rd_reg(a);

    // IMM mode direct load and field masking
    wr_reg(1, 32'h0001_2345);
    wr_reg(0, 32'hFFFF_FFFF);
    rd_reg(0);
    rd_reg(5);

    // Buffered writes then software commit
    wr_reg(8, 32'h0);
    wr_reg(0, 32'h0000_0AAA);
    wr_reg(3, 32'h0000_0BBB);
    rd_reg(9);
    wr_reg(9, 32'hDEAD_BEEF);
    idle(2);

    // Frame-sync commits: one per rising edge, held levels do not re-commit
    wr_reg(8, 32'h2);
    wr_reg(2, 32'h0000_0777);
    cur_fs = 1'b1;
    idle(5);
    cur_fs = 1'b0;
    wr_reg(2, 32'h0000_0999);
    cur_fs = 1'b1;
    idle(2);
    cur_fs = 1'b0;

    // Commit and shadow write in the same cycle
    wr_reg(1, 32'h0000_0111);
    wr_reg(9, 32'h0);
    cur_fs = 1'b1;
    wr_reg(1, 32'h0000_0555);
    cur_fs = 1'b0;
    rd_reg(5);
    rd_reg(9);
    wr_reg(9, 32'h0);
    rd_reg(5);

    // Ignored writes: out of range and read-only live
    wr_reg(12, 32'h1234_5678);
    wr_reg(5, 32'h000F_0F0F);
    rd_reg(12);
    rd_reg(5);

    // CTRL write with same-cycle frame_sync rise uses old FSYNC_EN
    wr_reg(8, 32'h0);
    cur_fs = 1'b1;
    wr_reg(8, 32'h2);
    cur_fs = 1'b0;
    idle(1);

    // Back-to-back commits
    wr_reg(0, 32'h0000_0321);
    wr_reg(9, 32'h0);
    wr_reg(9, 32'h0);
    idle(1);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) cur_fs = ~cur_fs;
      step($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom, cur_fs);
    end

    // Asynchronous reset mid-sequence
    wr_reg(8, 32'h0);
    wr_reg(2, 32'h0001_1111);
    wr_reg(9, 32'h0);
    chipselect = 1'b0;
    address    = AW'(2 * NCH);
    frame_sync = 1'b0;
    cur_fs     = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_out_port", out_port, '0);
    chk("async_reset_commit_pulse", commit_pulse, 1'b0);
    chk("async_reset_pending", pending, 1'b0);
    chk("async_reset_ctrl", readdata, 32'h1);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    rd_reg(2);
    rd_reg(6);
    wr_reg(3, 32'h0000_0042);
    idle(2);

    chipselect = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size() + st_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
